// File: rtl/copper_pkg.sv
// -----------------------------------------------------------------------------
// copper_pkg
// Shared definitions for the copper display-list co-processor: opcode values,
// instruction field positions, FSM state type and small decode helpers.
// Optional feature macro used by the copper RTL: COPPER_IRQ_EN.
// -----------------------------------------------------------------------------
package copper_pkg;

    localparam logic [1:0] OP_MOVE = 2'b00;
    localparam logic [1:0] OP_WAIT = 2'b01;
    localparam logic [1:0] OP_IRQ  = 2'b10;
    localparam logic [1:0] OP_END  = 2'b11;

    // Instruction field bit positions.
    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 14;
    localparam int REG_MSB = 11;
    localparam int REG_LSB = 8;
    localparam int DAT_MSB = 7;
    localparam int DAT_LSB = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_EXEC,
        ST_MOVE,
        ST_WAIT,
        ST_HALT
    } state_t;

    function automatic logic [1:0] instr_op(input logic [15:0] w);
        return w[OPC_MSB:OPC_LSB];
    endfunction

    function automatic logic [3:0] instr_reg(input logic [15:0] w);
        return w[REG_MSB:REG_LSB];
    endfunction

    function automatic logic [7:0] instr_dat(input logic [15:0] w);
        return w[DAT_MSB:DAT_LSB];
    endfunction

endpackage

// File: rtl/copper_pram.sv
// -----------------------------------------------------------------------------
// copper_pram
// Dual-port program RAM, 2^AW x 16 bits, both ports with 1-cycle registered
// reads.
//   cpu_addr    : byte address, [AW:1] entry, [0] selects high (1) / low (0) byte
//   cpu_wrdata  : byte write data
//   cpu_wren    : byte write strobe
//   cpu_rddata  : byte read data, valid the cycle after cpu_addr
//   cop_addr    : copper fetch address (read-only port)
//   cop_rddata  : 16-bit instruction word, valid the cycle after cop_addr
// A same-cycle CPU write and copper read of one entry returns the old word.
// -----------------------------------------------------------------------------
module copper_pram #(
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic [AW:0]   cpu_addr,
    input  logic [7:0]    cpu_wrdata,
    input  logic          cpu_wren,
    output logic [7:0]    cpu_rddata,
    input  logic [AW-1:0] cop_addr,
    output logic [15:0]   cop_rddata
);

    // NOTE: RAM contents and read registers have no reset; the CPU loads the
    // program before enabling the copper, and a reset path would prevent
    // mapping onto block RAM.
    logic [15:0]   mem_q [0:(1<<AW)-1];
    logic [7:0]    cpu_rddata_q;
    logic [15:0]   cop_rddata_q;
    logic [AW-1:0] cpu_idx;

    assign cpu_idx = cpu_addr[AW:1];

    // NOTE: non-blocking assignments here give read-before-write ordering, so
    // a colliding read sees the word as it was before this edge.
    always_ff @(posedge clk) begin
        if (cpu_wren) begin
            if (cpu_addr[0]) begin
                mem_q[cpu_idx][15:8] <= cpu_wrdata;
            end else begin
                mem_q[cpu_idx][7:0] <= cpu_wrdata;
            end
        end
        cpu_rddata_q <= cpu_addr[0] ? mem_q[cpu_idx][15:8] : mem_q[cpu_idx][7:0];
        cop_rddata_q <= mem_q[cop_addr];
    end

    assign cpu_rddata = cpu_rddata_q;
    assign cop_rddata = cop_rddata_q;

endmodule

// File: rtl/copper.sv
// -----------------------------------------------------------------------------
// copper
// Display-list co-processor issuing IO register writes in step with the video
// line counter. On each vblank rising edge it restarts its program at entry 0,
// executing MOVE / WAIT / IRQ / END instructions.
//   clk, reset        : clock, synchronous active-high reset
//   enable            : run enable; low forces IDLE and abandons any write
//   prog_addr/wrdata/wren/rddata : CPU byte port into program RAM
//   vpos, vblank      : current video line and vertical blank level
//   io_req/addr/wrdata, io_gnt : register write request, done on req && gnt
//   irq, irq_clr      : copper interrupt and its clear
//   pc                : program counter (debug)
// Optional feature: define COPPER_IRQ_EN to enable the IRQ opcode and irq
// output; otherwise IRQ is a NOP, irq is 0 and irq_clr is ignored.
// -----------------------------------------------------------------------------
module copper
    import copper_pkg::*;
#(
    parameter int PROG_AW = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic [PROG_AW:0]   prog_addr,
    input  logic [7:0]         prog_wrdata,
    input  logic               prog_wren,
    output logic [7:0]         prog_rddata,
    input  logic [7:0]         vpos,
    input  logic               vblank,
    output logic               io_req,
    output logic [3:0]         io_addr,
    output logic [7:0]         io_wrdata,
    input  logic               io_gnt,
    output logic               irq,
    input  logic               irq_clr,
    output logic [PROG_AW-1:0] pc
);

    state_t             state_q, state_d;
    logic [PROG_AW-1:0] pc_q, pc_d;
    logic               io_req_q, io_req_d;
    logic [3:0]         io_addr_q, io_addr_d;
    logic [7:0]         io_wrdata_q, io_wrdata_d;
    logic [7:0]         wait_line_q, wait_line_d;
    logic               vblank_q, vblank_d;
`ifdef COPPER_IRQ_EN
    logic               irq_q, irq_d;
`endif

    logic [15:0] instr;
    logic        restart;

    copper_pram #(.AW(PROG_AW)) u_pram (
        .clk        (clk),
        .cpu_addr   (prog_addr),
        .cpu_wrdata (prog_wrdata),
        .cpu_wren   (prog_wren),
        .cpu_rddata (prog_rddata),
        .cop_addr   (pc_q),
        .cop_rddata (instr)
    );

    assign vblank_d = vblank;
    assign restart  = vblank && !vblank_q;

    always_comb begin
        // NOTE: every next-state value defaults to its current value first, so
        // no path through the case leaves a signal unassigned (no latches).
        state_d     = state_q;
        pc_d        = pc_q;
        io_req_d    = io_req_q;
        io_addr_d   = io_addr_q;
        io_wrdata_d = io_wrdata_q;
        wait_line_d = wait_line_q;
`ifdef COPPER_IRQ_EN
        irq_d       = irq_q && !irq_clr;
`endif

        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d = ST_HALT;
                end
            end
            ST_FETCH: begin
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                case (instr_op(instr))
                    OP_MOVE: begin
                        io_addr_d   = instr_reg(instr);
                        io_wrdata_d = instr_dat(instr);
                        io_req_d    = 1'b1;
                        state_d     = ST_MOVE;
                    end
                    OP_WAIT: begin
                        wait_line_d = instr_dat(instr);
                        state_d     = ST_WAIT;
                    end
                    OP_IRQ: begin
`ifdef COPPER_IRQ_EN
                        // Set beats a simultaneous irq_clr.
                        irq_d = 1'b1;
`endif
                        pc_d    = pc_q + 1'b1;
                        state_d = ST_FETCH;
                    end
                    default: begin
                        state_d = ST_HALT;
                    end
                endcase
            end
            ST_MOVE: begin
                if (io_gnt) begin
                    io_req_d = 1'b0;
                    pc_d     = pc_q + 1'b1;
                    state_d  = ST_FETCH;
                end
            end
            ST_WAIT: begin
                if (vpos == wait_line_q) begin
                    pc_d    = pc_q + 1'b1;
                    state_d = ST_FETCH;
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Frame restart overrides normal sequencing. A write granted this
        // cycle has already happened on the bus; an ungranted one is dropped.
        if (restart && state_q != ST_IDLE) begin
            pc_d     = '0;
            io_req_d = 1'b0;
            state_d  = ST_FETCH;
        end

        // Disable has the final say from any state.
        if (!enable) begin
            io_req_d = 1'b0;
            state_d  = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            pc_q        <= '0;
            io_req_q    <= 1'b0;
            io_addr_q   <= '0;
            io_wrdata_q <= '0;
            wait_line_q <= '0;
            vblank_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            io_req_q    <= io_req_d;
            io_addr_q   <= io_addr_d;
            io_wrdata_q <= io_wrdata_d;
            wait_line_q <= wait_line_d;
            vblank_q    <= vblank_d;
        end
    end

`ifdef COPPER_IRQ_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end
    assign irq = irq_q;
`else
    logic unused_irq_clr;
    assign unused_irq_clr = irq_clr;
    assign irq = 1'b0;
`endif

    assign io_req    = io_req_q;
    assign io_addr   = io_addr_q;
    assign io_wrdata = io_wrdata_q;
    assign pc        = pc_q;

endmodule

// File: tb/tb_copper.sv
// -----------------------------------------------------------------------------
// tb_copper
// Self-checking bench for copper. Inputs change 1 time unit after the rising
// edge; bus writes are collected on the falling edge whenever io_req && io_gnt.
// Expected values come from the instruction semantics and cycle costs
// (FETCH/EXEC/MOVE = 3 cycles, restart -> FETCH next cycle), applied to a copy
// of the program kept in the bench.
// -----------------------------------------------------------------------------
module tb_copper;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [8:0]  prog_addr;
    logic [7:0]  prog_wrdata;
    logic        prog_wren;
    logic [7:0]  prog_rddata;
    logic [7:0]  vpos;
    logic        vblank;
    logic        io_req;
    logic [3:0]  io_addr;
    logic [7:0]  io_wrdata;
    logic        io_gnt;
    logic        irq;
    logic        irq_clr;
    logic [7:0]  pc;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    typedef struct {
        int         c;
        logic [3:0] a;
        logic [7:0] d;
    } wr_t;

    wr_t         wr_q[$];
    wr_t         wr_now;
    logic [15:0] model_prog [256];

    copper dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .prog_addr   (prog_addr),
        .prog_wrdata (prog_wrdata),
        .prog_wren   (prog_wren),
        .prog_rddata (prog_rddata),
        .vpos        (vpos),
        .vblank      (vblank),
        .io_req      (io_req),
        .io_addr     (io_addr),
        .io_wrdata   (io_wrdata),
        .io_gnt      (io_gnt),
        .irq         (irq),
        .irq_clr     (irq_clr),
        .pc          (pc)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (io_req && io_gnt) begin
            wr_now.c = cyc;
            wr_now.a = io_addr;
            wr_now.d = io_wrdata;
            wr_q.push_back(wr_now);
        end
    end

    function automatic logic [15:0] enc_move(input logic [3:0] r, input logic [7:0] d);
        return {2'b00, 2'b00, r, d};
    endfunction
    function automatic logic [15:0] enc_wait(input logic [7:0] l);
        return {2'b01, 6'b0, l};
    endfunction
    function automatic logic [15:0] enc_irq();
        return {2'b10, 14'b0};
    endfunction
    function automatic logic [15:0] enc_end();
        return {2'b11, 14'b0};
    endfunction

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic load_word(input int idx, input logic [15:0] w);
        prog_wren   = 1'b1;
        prog_addr   = {idx[7:0], 1'b0};
        prog_wrdata = w[7:0];
        tick();
        prog_addr   = {idx[7:0], 1'b1};
        prog_wrdata = w[15:8];
        tick();
        prog_wren   = 1'b0;
        model_prog[idx] = w;
    endtask

    // Returns in the first FETCH cycle after a sampled vblank rising edge.
    task automatic restart();
        vblank = 1'b0;
        tick();
        vblank = 1'b1;
        tick();
        vblank = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(3);
        n_tests++; if (io_req !== 1'b0) begin n_fail++; $display("FAIL reset_io_req: got %0b want 0", io_req); end
        n_tests++; if (io_addr !== 4'h0) begin n_fail++; $display("FAIL reset_io_addr: got %0h want 0", io_addr); end
        n_tests++; if (io_wrdata !== 8'h00) begin n_fail++; $display("FAIL reset_io_wrdata: got %0h want 0", io_wrdata); end
        n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %0b want 0", irq); end
        n_tests++; if (pc !== 8'h00) begin n_fail++; $display("FAIL reset_pc: got %0h want 0", pc); end
        reset = 1'b0;
        tick();
    endtask

    // WAIT line / MOVE / END, grant always given; first pass uses the fixed
    // values, later passes random line, register and data.
    task automatic test_wait_move();
        logic [7:0] line;
        logic [3:0] r;
        logic [7:0] d;
        int         c0;
        enable = 1'b1;
        io_gnt = 1'b1;
        vpos   = 8'd10;
        for (int it = 0; it < 4; it++) begin
            line = (it == 0) ? 8'd20 : 8'($urandom_range(30, 200));
            r    = (it == 0) ? 4'd3 : 4'($urandom_range(0, 15));
            d    = (it == 0) ? 8'h55 : 8'($urandom_range(0, 255));
            load_word(0, enc_wait(line));
            load_word(1, enc_move(r, d));
            load_word(2, enc_end());
            restart();
            tick(5);
            wr_q.delete();
            tick(10);
            n_tests++; if (wr_q.size() != 0) begin n_fail++; $display("FAIL wait_early_write: got %0d writes want 0", wr_q.size()); end
            c0   = cyc;
            vpos = line;
            tick();
            vpos = line + 8'd1;
            tick(30);
            n_tests++;
            if (wr_q.size() != 1) begin
                n_fail++; $display("FAIL wait_move_count: got %0d writes want 1", wr_q.size());
            end else begin
                if (wr_q[0].c != c0 + 3 || wr_q[0].a !== r || wr_q[0].d !== d) begin
                    n_fail++;
                    $display("FAIL wait_move_write: got cyc+%0d a=%0h d=%0h want cyc+3 a=%0h d=%0h",
                             wr_q[0].c - c0, wr_q[0].a, wr_q[0].d, r, d);
                end
            end
            n_tests++; if (pc !== 8'd2) begin n_fail++; $display("FAIL wait_move_pc: got %0d want 2", pc); end
            vpos = 8'd10;
        end
    endtask

    task automatic test_grant_stall();
        bit seen = 0;
        load_word(0, enc_wait(8'd20));
        load_word(1, enc_move(4'd3, 8'h55));
        load_word(2, enc_end());
        io_gnt = 1'b0;
        vpos   = 8'd10;
        restart();
        tick(5);
        wr_q.delete();
        vpos = 8'd20;
        tick();
        vpos = 8'd21;
        for (int k = 0; k < 10; k++) begin
            if (io_req) begin seen = 1; break; end
            tick();
        end
        n_tests++; if (!seen) begin n_fail++; $display("FAIL stall_req_timeout: io_req got 0 want 1 within 10 cycles"); end
        for (int k = 0; k < 5; k++) begin
            n_tests++;
            if (io_req !== 1'b1 || io_addr !== 4'd3 || io_wrdata !== 8'h55) begin
                n_fail++;
                $display("FAIL stall_hold_%0d: got req=%0b a=%0h d=%0h want req=1 a=3 d=55", k, io_req, io_addr, io_wrdata);
            end
            tick();
        end
        io_gnt = 1'b1;
        n_tests++; if (io_req !== 1'b1) begin n_fail++; $display("FAIL stall_req_6th: got %0b want 1", io_req); end
        tick();
        n_tests++; if (io_req !== 1'b0) begin n_fail++; $display("FAIL stall_req_drop: got %0b want 0", io_req); end
        tick(10);
        n_tests++; if (wr_q.size() != 1) begin n_fail++; $display("FAIL stall_write_count: got %0d want 1", wr_q.size()); end
    endtask

    task automatic test_restart_drop();
        load_word(0, enc_move(4'd7, 8'hA1));
        load_word(1, enc_end());
        io_gnt = 1'b0;
        restart();
        tick(2);
        wr_q.delete();
        n_tests++; if (io_req !== 1'b1) begin n_fail++; $display("FAIL restart_pending_req: got %0b want 1", io_req); end
        tick(3);
        vblank = 1'b1;
        tick();
        vblank = 1'b0;
        n_tests++; if (io_req !== 1'b0) begin n_fail++; $display("FAIL restart_req_drop: got %0b want 0", io_req); end
        n_tests++; if (pc !== 8'd0) begin n_fail++; $display("FAIL restart_pc: got %0d want 0", pc); end
        io_gnt = 1'b1;
        tick(10);
        n_tests++;
        if (wr_q.size() != 1) begin
            n_fail++; $display("FAIL restart_rerun_count: got %0d want 1", wr_q.size());
        end else if (wr_q[0].a !== 4'd7 || wr_q[0].d !== 8'hA1) begin
            n_fail++; $display("FAIL restart_rerun_write: got a=%0h d=%0h want a=7 d=a1", wr_q[0].a, wr_q[0].d);
        end
    endtask

    task automatic test_enable();
        // Drop enable with a MOVE pending.
        load_word(0, enc_move(4'd9, 8'h3C));
        load_word(1, enc_end());
        io_gnt = 1'b0;
        restart();
        tick(2);
        n_tests++; if (io_req !== 1'b1) begin n_fail++; $display("FAIL enable_move_pending: got %0b want 1", io_req); end
        enable = 1'b0;
        tick();
        n_tests++; if (io_req !== 1'b0) begin n_fail++; $display("FAIL enable_move_drop: got %0b want 0", io_req); end
        wr_q.delete();
        enable = 1'b1;
        io_gnt = 1'b1;
        tick(8);
        n_tests++; if (wr_q.size() != 0) begin n_fail++; $display("FAIL enable_move_resume: got %0d writes want 0", wr_q.size()); end

        // Drop enable in WAIT, re-enable mid-frame with the line matching.
        load_word(0, enc_wait(8'd20));
        load_word(1, enc_move(4'd3, 8'h55));
        load_word(2, enc_end());
        vpos = 8'd5;
        restart();
        tick(4);
        enable = 1'b0;
        tick();
        n_tests++; if (io_req !== 1'b0) begin n_fail++; $display("FAIL enable_wait_req: got %0b want 0", io_req); end
        n_tests++; if (pc !== 8'd0) begin n_fail++; $display("FAIL enable_wait_pc: got %0d want 0", pc); end
        wr_q.delete();
        vpos = 8'd20;
        tick(5);
        enable = 1'b1;
        tick(12);
        n_tests++; if (wr_q.size() != 0) begin n_fail++; $display("FAIL enable_midframe_write: got %0d writes want 0", wr_q.size()); end
        restart();
        tick(12);
        n_tests++; if (wr_q.size() != 1) begin n_fail++; $display("FAIL enable_next_frame: got %0d writes want 1", wr_q.size()); end
        vpos = 8'd10;
    endtask

    task automatic test_irq();
        logic exp_irq;
`ifdef COPPER_IRQ_EN
        exp_irq = 1'b1;
`else
        exp_irq = 1'b0;
`endif
        load_word(0, enc_irq());
        load_word(1, enc_end());
        irq_clr = 1'b0;
        restart();
        tick(4);
        n_tests++; if (irq !== exp_irq) begin n_fail++; $display("FAIL irq_set: got %0b want %0b", irq, exp_irq); end
        n_tests++; if (pc !== 8'd1) begin n_fail++; $display("FAIL irq_pc: got %0d want 1", pc); end
        tick(5);
        n_tests++; if (irq !== exp_irq) begin n_fail++; $display("FAIL irq_hold: got %0b want %0b", irq, exp_irq); end
        irq_clr = 1'b1;
        tick();
        irq_clr = 1'b0;
        n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_clear: got %0b want 0", irq); end
        restart();
        tick();
        irq_clr = 1'b1;
        tick();
        irq_clr = 1'b0;
        n_tests++; if (irq !== exp_irq) begin n_fail++; $display("FAIL irq_set_wins: got %0b want %0b", irq, exp_irq); end
        tick(3);
        irq_clr = 1'b1;
        tick();
        irq_clr = 1'b0;
    endtask

    task automatic test_back_to_back();
        int c0;
        int nchk;
        for (int i = 0; i < 256; i++) begin
            load_word(i, enc_move(4'($urandom_range(0, 15)), 8'($urandom_range(0, 255))));
        end
        io_gnt = 1'b1;
        restart();
        c0 = cyc;
        wr_q.delete();
        tick(3 * 258 + 1);
        n_tests++; if (pc !== 8'd2) begin n_fail++; $display("FAIL wrap_pc: got %0d want 2", pc); end
        tick(3 * 12);
        n_tests++; if (wr_q.size() < 270) begin n_fail++; $display("FAIL wrap_count: got %0d writes want >= 270", wr_q.size()); end
        nchk = (wr_q.size() < 270) ? wr_q.size() : 270;
        for (int i = 0; i < nchk; i++) begin
            n_tests++;
            if (wr_q[i].c != c0 + 2 + 3 * i ||
                wr_q[i].a !== model_prog[i % 256][11:8] ||
                wr_q[i].d !== model_prog[i % 256][7:0]) begin
                n_fail++;
                $display("FAIL wrap_write_%0d: got cyc+%0d a=%0h d=%0h want cyc+%0d a=%0h d=%0h",
                         i, wr_q[i].c - c0, wr_q[i].a, wr_q[i].d,
                         2 + 3 * i, model_prog[i % 256][11:8], model_prog[i % 256][7:0]);
            end
        end

        // Random grant pattern: same write order, timing left free.
        restart();
        wr_q.delete();
        repeat (600) begin
            io_gnt = 1'($urandom_range(0, 1));
            tick();
        end
        io_gnt = 1'b1;
        n_tests++; if (wr_q.size() < 50) begin n_fail++; $display("FAIL rand_gnt_count: got %0d writes want >= 50", wr_q.size()); end
        for (int i = 0; i < wr_q.size(); i++) begin
            n_tests++;
            if (wr_q[i].a !== model_prog[i % 256][11:8] || wr_q[i].d !== model_prog[i % 256][7:0]) begin
                n_fail++;
                $display("FAIL rand_gnt_write_%0d: got a=%0h d=%0h want a=%0h d=%0h",
                         i, wr_q[i].a, wr_q[i].d, model_prog[i % 256][11:8], model_prog[i % 256][7:0]);
            end
        end
    endtask

    task automatic test_cpu_port();
        int idx;
        load_word(5, {8'hCD, 8'hAB});
        for (int it = 0; it < 4; it++) begin
            idx = (it == 0) ? 5 : int'($urandom_range(0, 255));
            prog_addr = {idx[7:0], 1'b0};
            tick();
            n_tests++; if (prog_rddata !== model_prog[idx][7:0]) begin n_fail++; $display("FAIL cpu_read_lo_%0d: got %0h want %0h", idx, prog_rddata, model_prog[idx][7:0]); end
            prog_addr = {idx[7:0], 1'b1};
            tick();
            n_tests++; if (prog_rddata !== model_prog[idx][15:8]) begin n_fail++; $display("FAIL cpu_read_hi_%0d: got %0h want %0h", idx, prog_rddata, model_prog[idx][15:8]); end
        end
    endtask

    initial begin
        reset       = 1'b1;
        enable      = 1'b0;
        prog_addr   = '0;
        prog_wrdata = '0;
        prog_wren   = 1'b0;
        vpos        = 8'd10;
        vblank      = 1'b0;
        io_gnt      = 1'b0;
        irq_clr     = 1'b0;
        test_reset();
        test_wait_move();
        test_grant_stall();
        test_restart_drop();
        test_enable();
        test_irq();
        test_back_to_back();
        test_cpu_port();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
